// File: rtl/pipe_regs.sv
// Pipeline register bank for a five-stage RV32 core: PC, IF/ID, ID/EX, EX/MEM and MEM/WB,
// plus a retired-instruction counter driven by the write-back valid bit.
module pipe_regs #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        stall_f,
  input  logic        stall_d,
  input  logic        flush_d,
  input  logic        flush_e,

  input  logic [31:0] pc_next_f,
  output logic [31:0] pc_f,

  input  logic [31:0] instr_f,
  input  logic [31:0] pc_plus4_f,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc_plus4_d,
  output logic        valid_d,

  input  logic [31:0] rd1_d,
  input  logic [31:0] rd2_d,
  input  logic [31:0] imm_ext_d,
  input  logic [4:0]  rs1_d,
  input  logic [4:0]  rs2_d,
  input  logic [4:0]  rd_d,
  input  logic        reg_write_d,
  input  logic        mem_write_d,
  input  logic [1:0]  res_src_d,
  output logic [31:0] rd1_e,
  output logic [31:0] rd2_e,
  output logic [31:0] imm_ext_e,
  output logic [31:0] pc_e,
  output logic [31:0] pc_plus4_e,
  output logic [4:0]  rs1_e,
  output logic [4:0]  rs2_e,
  output logic [4:0]  rd_e,
  output logic        reg_write_e,
  output logic        mem_write_e,
  output logic [1:0]  res_src_e,
  output logic        res_src_e_b0,
  output logic        valid_e,

  input  logic [31:0] alu_result_e,
  input  logic [31:0] write_data_e,
  output logic [31:0] alu_result_m,
  output logic [31:0] write_data_m,
  output logic [31:0] pc_plus4_m,
  output logic [4:0]  rd_m,
  output logic        reg_write_m,
  output logic        mem_write_m,
  output logic        valid_m,
  output logic [1:0]  res_src_m,

  input  logic [31:0] read_data_m,
  output logic [31:0] alu_result_w,
  output logic [31:0] read_data_w,
  output logic [31:0] pc_plus4_w,
  output logic [4:0]  rd_w,
  output logic        reg_write_w,
  output logic        valid_w,
  output logic [1:0]  res_src_w,

  output logic [63:0] instret
);

  logic [63:0] instret_reg;

  assign instret      = instret_reg;
  assign res_src_e_b0 = res_src_e[0];

  // Program counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_f <= RESET_PC;
    end else if (!stall_f) begin
      pc_f <= pc_next_f;
    end
  end

  // IF/ID: flush wins over stall so a squashed slot never survives a stall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_d    <= NOP_INSTR;
      pc_d       <= '0;
      pc_plus4_d <= '0;
      valid_d    <= 1'b0;
    end else if (flush_d) begin
      instr_d    <= NOP_INSTR;
      pc_d       <= '0;
      pc_plus4_d <= '0;
      valid_d    <= 1'b0;
    end else if (!stall_d) begin
      instr_d    <= instr_f;
      pc_d       <= pc_f;
      pc_plus4_d <= pc_plus4_f;
      valid_d    <= 1'b1;
    end
  end

  // ID/EX: side-effecting controls are gated by valid_d so a bubble can never write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd1_e       <= '0;
      rd2_e       <= '0;
      imm_ext_e   <= '0;
      pc_e        <= '0;
      pc_plus4_e  <= '0;
      rs1_e       <= '0;
      rs2_e       <= '0;
      rd_e        <= '0;
      reg_write_e <= 1'b0;
      mem_write_e <= 1'b0;
      res_src_e   <= '0;
      valid_e     <= 1'b0;
    end else if (flush_e) begin
      rd1_e       <= '0;
      rd2_e       <= '0;
      imm_ext_e   <= '0;
      pc_e        <= '0;
      pc_plus4_e  <= '0;
      rs1_e       <= '0;
      rs2_e       <= '0;
      rd_e        <= '0;
      reg_write_e <= 1'b0;
      mem_write_e <= 1'b0;
      res_src_e   <= '0;
      valid_e     <= 1'b0;
    end else begin
      rd1_e       <= rd1_d;
      rd2_e       <= rd2_d;
      imm_ext_e   <= imm_ext_d;
      pc_e        <= pc_d;
      pc_plus4_e  <= pc_plus4_d;
      rs1_e       <= rs1_d;
      rs2_e       <= rs2_d;
      rd_e        <= rd_d;
      reg_write_e <= reg_write_d & valid_d;
      mem_write_e <= mem_write_d & valid_d;
      res_src_e   <= res_src_d;
      valid_e     <= valid_d;
    end
  end

  // EX/MEM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_result_m <= '0;
      write_data_m <= '0;
      pc_plus4_m   <= '0;
      rd_m         <= '0;
      reg_write_m  <= 1'b0;
      mem_write_m  <= 1'b0;
      valid_m      <= 1'b0;
      res_src_m    <= '0;
    end else begin
      alu_result_m <= alu_result_e;
      write_data_m <= write_data_e;
      pc_plus4_m   <= pc_plus4_e;
      rd_m         <= rd_e;
      reg_write_m  <= reg_write_e;
      mem_write_m  <= mem_write_e;
      valid_m      <= valid_e;
      res_src_m    <= res_src_e;
    end
  end

  // MEM/WB
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_result_w <= '0;
      read_data_w  <= '0;
      pc_plus4_w   <= '0;
      rd_w         <= '0;
      reg_write_w  <= 1'b0;
      valid_w      <= 1'b0;
      res_src_w    <= '0;
    end else begin
      alu_result_w <= alu_result_m;
      read_data_w  <= read_data_m;
      pc_plus4_w   <= pc_plus4_m;
      rd_w         <= rd_m;
      reg_write_w  <= reg_write_m;
      valid_w      <= valid_m;
      res_src_w    <= res_src_m;
    end
  end

  // Counts an instruction as retired on the edge that consumes it from MEM/WB
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instret_reg <= '0;
    end else if (valid_w) begin
      instret_reg <= instret_reg + 64'd1;
    end
  end

endmodule
